// File: rtl/hangman_pkg.sv
// Shared constants, state encoding and letter helpers for the guess-evaluation stage.
package hangman_pkg;

    localparam int CHAR_W     = 5;
    localparam int WORD_LEN   = 5;
    localparam int MAX_TRIES  = 7;
    localparam int ALPHA_SIZE = 26;
    localparam int TRIES_W    = $clog2(MAX_TRIES + 1);

    localparam logic [CHAR_W-1:0] LETTER_Z = 5'd25;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_CMP   = 3'd2,
        ST_UPD   = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } state_e;

    function automatic logic is_letter(input logic [CHAR_W-1:0] code);
        return (code <= LETTER_Z);
    endfunction

endpackage

// File: rtl/hangman_letter_match.sv
// Combinational compare of one letter code against every position of the word.
module hangman_letter_match
    import hangman_pkg::*;
(
    input  logic [WORD_LEN*CHAR_W-1:0] word_i,
    input  logic [CHAR_W-1:0]          char_i,
    output logic [WORD_LEN-1:0]        mask_o,
    output logic                       valid_o
);

    // Per-position equality; repeated letters set several mask bits at once
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            mask_o[i] = (word_i[i*CHAR_W +: CHAR_W] == char_i);
        end
    end

    // Codes above 'z' are not letters
    always_comb begin
        valid_o = is_letter(char_i);
    end

endmodule

// File: rtl/guess_datapath.sv
// Guess-evaluation stage: secret word, used letters, revealed positions and try counter,
// with a registered per-guess result pulse and sticky win/lose flags.
module guess_datapath
    import hangman_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       word_load,
    input  logic [WORD_LEN*CHAR_W-1:0] word_in,
    input  logic                       guess_valid,
    input  logic [CHAR_W-1:0]          guess_char,
    output logic                       guess_ready,
    output logic                       result_valid,
    output logic                       hit,
    output logic                       dup,
    output logic                       invalid,
    output logic [WORD_LEN-1:0]        match_mask,
    output logic [WORD_LEN-1:0]        revealed,
    output logic [TRIES_W-1:0]         tries_left,
    output logic                       win,
    output logic                       lose
);

    state_e                     state_q, state_d;
    logic [WORD_LEN*CHAR_W-1:0] word_q;
    logic [CHAR_W-1:0]          char_q;
    logic [WORD_LEN-1:0]        cmp_mask_q;
    logic                       cmp_inv_q;
    logic                       cmp_used_q;
    logic [ALPHA_SIZE-1:0]      used_q;
    logic [WORD_LEN-1:0]        revealed_q;
    logic [TRIES_W-1:0]         tries_q;
    logic                       win_q, lose_q;
    logic                       rv_q, hit_q, dup_q, inv_q;
    logic [WORD_LEN-1:0]        mm_q;

    logic [WORD_LEN-1:0]        match_s;
    logic                       letter_ok_s;
    logic                       guess_ready_s, accept_s, upd_s;
    logic                       is_inv_s, is_dup_s, is_hit_s, is_miss_s;
    logic [WORD_LEN-1:0]        revealed_upd_s;
    logic [TRIES_W-1:0]         tries_upd_s;
    logic                       win_cond_s, lose_cond_s;
    logic [31:0]                used_ext_s, char_oh_s;

    hangman_letter_match u_match (
        .word_i  (word_q),
        .char_i  (char_q),
        .mask_o  (match_s),
        .valid_o (letter_ok_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; word_load overrides everything, including an in-flight guess
    always_comb begin
        state_d = state_q;
        if (word_load) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_ARMED: state_d = accept_s ? ST_CMP : ST_ARMED;
                ST_CMP:   state_d = ST_UPD;
                ST_UPD: begin
                    if (win_cond_s) begin
                        state_d = ST_WIN;
                    end else if (lose_cond_s) begin
                        state_d = ST_LOSE;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_WIN:   state_d = ST_WIN;
                ST_LOSE:  state_d = ST_LOSE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs and the mutually exclusive outcome decode of the update cycle
    always_comb begin
        guess_ready_s = (state_q == ST_ARMED) && !word_load;
        accept_s      = guess_valid && guess_ready_s;
        upd_s         = (state_q == ST_UPD);
        is_inv_s      = upd_s && cmp_inv_q;
        is_dup_s      = upd_s && !cmp_inv_q && cmp_used_q;
        is_hit_s      = upd_s && !cmp_inv_q && !cmp_used_q && (cmp_mask_q != '0);
        is_miss_s     = upd_s && !cmp_inv_q && !cmp_used_q && (cmp_mask_q == '0);
        if (is_hit_s) begin
            revealed_upd_s = revealed_q | cmp_mask_q;
        end else begin
            revealed_upd_s = revealed_q;
        end
        if (is_miss_s && (tries_q != '0)) begin
            tries_upd_s = tries_q - TRIES_W'(1);
        end else begin
            tries_upd_s = tries_q;
        end
        win_cond_s  = &revealed_upd_s;
        lose_cond_s = (tries_upd_s == '0);
        used_ext_s  = {{(32-ALPHA_SIZE){1'b0}}, used_q};
        char_oh_s   = 32'd1 << char_q;
    end

    // Game datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            char_q     <= '0;
            cmp_mask_q <= '0;
            cmp_inv_q  <= 1'b0;
            cmp_used_q <= 1'b0;
            used_q     <= '0;
            revealed_q <= '0;
            tries_q    <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            rv_q       <= 1'b0;
            hit_q      <= 1'b0;
            dup_q      <= 1'b0;
            inv_q      <= 1'b0;
            mm_q       <= '0;
        end else if (word_load) begin
            word_q     <= word_in;
            used_q     <= '0;
            revealed_q <= '0;
            tries_q    <= TRIES_W'(MAX_TRIES);
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            rv_q       <= 1'b0;
            hit_q      <= 1'b0;
            dup_q      <= 1'b0;
            inv_q      <= 1'b0;
            mm_q       <= '0;
        end else begin
            rv_q  <= upd_s;
            hit_q <= is_hit_s;
            dup_q <= is_dup_s;
            inv_q <= is_inv_s;
            mm_q  <= is_hit_s ? cmp_mask_q : '0;
            if (accept_s) begin
                char_q <= guess_char;
            end
            if (state_q == ST_CMP) begin
                cmp_mask_q <= match_s;
                cmp_inv_q  <= !letter_ok_s;
                cmp_used_q <= letter_ok_s && used_ext_s[char_q];
            end
            if (upd_s) begin
                revealed_q <= revealed_upd_s;
                tries_q    <= tries_upd_s;
                win_q      <= win_cond_s;
                lose_q     <= !win_cond_s && lose_cond_s;
                if (is_hit_s || is_miss_s) begin
                    used_q <= used_q | char_oh_s[ALPHA_SIZE-1:0];
                end
            end
        end
    end

    assign guess_ready  = guess_ready_s;
    assign result_valid = rv_q;
    assign hit          = hit_q;
    assign dup          = dup_q;
    assign invalid      = inv_q;
    assign match_mask   = mm_q;
    assign revealed     = revealed_q;
    assign tries_left   = tries_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_guess_datapath.sv
// Directed and randomized bench for guess_datapath against a game-level reference model.
module tb_guess_datapath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        word_load = 1'b0;
    logic [24:0] word_in = '0;
    logic        guess_valid = 1'b0;
    logic [4:0]  guess_char = '0;
    logic        guess_ready, result_valid, hit, dup, invalid, win, lose;
    logic [4:0]  match_mask, revealed;
    logic [2:0]  tries_left;

    int vectors = 0;
    int miscompares = 0;

    int       m_word[5];
    bit       m_used[26];
    bit [4:0] m_rev;
    int       m_tries;
    bit       m_win, m_lose;

    guess_datapath dut (
        .clk(clk), .rst_n(rst_n), .word_load(word_load), .word_in(word_in),
        .guess_valid(guess_valid), .guess_char(guess_char), .guess_ready(guess_ready),
        .result_valid(result_valid), .hit(hit), .dup(dup), .invalid(invalid),
        .match_mask(match_mask), .revealed(revealed), .tries_left(tries_left),
        .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".ready"}, 32'(guess_ready), 32'd0);
        chk({tag, ".flags"}, {28'd0, result_valid, hit, dup, invalid}, 32'd0);
        chk({tag, ".mask"}, {27'd0, match_mask}, 32'd0);
        chk({tag, ".revealed"}, {27'd0, revealed}, 32'd0);
        chk({tag, ".tries"}, {29'd0, tries_left}, 32'd0);
        chk({tag, ".winlose"}, {30'd0, win, lose}, 32'd0);
    endtask

    task automatic load_word(input int a0, input int a1, input int a2, input int a3, input int a4);
        m_word[0] = a0; m_word[1] = a1; m_word[2] = a2; m_word[3] = a3; m_word[4] = a4;
        for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
        m_rev = '0; m_tries = 7; m_win = 1'b0; m_lose = 1'b0;
        @(negedge clk);
        word_load = 1'b1;
        for (int i = 0; i < 5; i++) word_in[i*5 +: 5] = 5'(m_word[i]);
        #1;
        chk("ready_during_load", 32'(guess_ready), 32'd0);
        @(negedge clk);
        word_load = 1'b0;
        #1;
        chk("load.tries", 32'(tries_left), 32'd7);
        chk("load.ready", 32'(guess_ready), 32'd1);
        chk("load.state", {27'd0, revealed, win, lose, result_valid}, 32'd0);
    endtask

    task automatic do_guess(input int c);
        int n;
        bit [4:0] e_mask = '0;
        bit e_hit = 1'b0, e_dup = 1'b0, e_inv = 1'b0;
        if (c >= 26) begin
            e_inv = 1'b1;
        end else if (m_used[c]) begin
            e_dup = 1'b1;
        end else begin
            for (int i = 0; i < 5; i++) if (m_word[i] == c) e_mask[i] = 1'b1;
            m_used[c] = 1'b1;
            if (e_mask != 0) begin
                e_hit = 1'b1;
                m_rev = m_rev | e_mask;
            end else if (m_tries > 0) begin
                m_tries = m_tries - 1;
            end
        end
        m_win  = (m_rev == 5'b11111);
        m_lose = !m_win && (m_tries == 0);

        @(negedge clk);
        guess_valid = 1'b1;
        guess_char  = 5'(c);
        #1;
        n = 0;
        while (!guess_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            chk("ready_timeout", 32'd0, 32'd1);
            guess_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        guess_valid = 1'b0;
        guess_char  = '0;
        n = 1;
        while (!result_valid && n < 10) begin
            @(negedge clk); n++;
        end
        chk("latency", 32'(n), 32'd3);
        chk("flags", {29'd0, hit, dup, invalid}, {29'd0, e_hit, e_dup, e_inv});
        chk("match_mask", {27'd0, match_mask}, {27'd0, e_mask});
        chk("revealed", {27'd0, revealed}, {27'd0, m_rev});
        chk("tries_left", 32'(tries_left), 32'(m_tries));
        chk("win_lose", {30'd0, win, lose}, {30'd0, m_win, m_lose});
        chk("ready_after", 32'(guess_ready), 32'(!(m_win || m_lose)));
        @(negedge clk);
        chk("pulse_clear", 32'(result_valid), 32'd0);
    endtask

    initial begin
        int gs[7] = '{0, 1, 2, 3, 5, 6, 7};
        int nt[5] = '{13, 14, 19, 17, 4};
        int n;

        // Reset state
        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero_outputs("post_reset");

        // Win with "notre"
        load_word(13, 14, 19, 17, 4);
        for (int i = 0; i < 5; i++) do_guess(nt[i]);
        chk("notre.win", 32'(win), 32'd1);

        // Held guess_valid in WIN has no effect
        @(negedge clk);
        guess_valid = 1'b1;
        guess_char  = 5'd13;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (result_valid || guess_ready) n++;
        end
        guess_valid = 1'b0;
        chk("win_hold_no_effect", 32'(n), 32'd0);

        // Lose with seven misses
        load_word(13, 14, 19, 17, 4);
        for (int i = 0; i < 7; i++) do_guess(gs[i]);
        chk("notre.lose", 32'(lose), 32'd1);

        // Duplicate and invalid guesses
        load_word(13, 14, 19, 17, 4);
        do_guess(13);
        do_guess(13);
        do_guess(27);
        do_guess(31);
        do_guess(5);
        do_guess(5);

        // Repeated letters
        load_word(18, 4, 4, 12, 18);
        do_guess(4);
        do_guess(18);
        do_guess(12);

        // word_load during the compare cycle discards the guess
        load_word(13, 14, 19, 17, 4);
        do_guess(1);
        @(negedge clk);
        guess_valid = 1'b1;
        guess_char  = 5'd13;
        @(posedge clk);
        @(negedge clk);
        guess_valid = 1'b0;
        word_load   = 1'b1;
        word_in     = {5'd3, 5'd2, 5'd1, 5'd0, 5'd25};
        @(negedge clk);
        word_load = 1'b0;
        #1;
        chk("cmp_load.tries", 32'(tries_left), 32'd7);
        chk("cmp_load.ready", 32'(guess_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (result_valid) n++;
            @(negedge clk);
        end
        chk("cmp_load.no_pulse", 32'(n), 32'd0);
        m_word = '{25, 0, 1, 2, 3};
        for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
        m_rev = '0; m_tries = 7; m_win = 1'b0; m_lose = 1'b0;
        do_guess(0);
        do_guess(13);

        // Asynchronous reset mid-game
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized games
        for (int g = 0; g < 8; g++) begin
            load_word($urandom_range(25, 0), $urandom_range(25, 0), $urandom_range(25, 0),
                      $urandom_range(25, 0), $urandom_range(25, 0));
            for (int k = 0; k < 40 && !(m_win || m_lose); k++) begin
                if ($urandom_range(3, 0) == 0) do_guess(m_word[$urandom_range(4, 0)]);
                else do_guess($urandom_range(31, 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
